mem_bus_arbiter: RTL

Two-master, single-slave memory arbiter between the core's instruction-fetch port and its load/store port on one side and a single shared memory port on the other. It replaces the core's direct per-port memory access with a valid/ready request and valid response protocol to a multi-cycle memory. It carries exactly one outstanding transaction at a time and routes the registered response back to the master that issued it.

---
 rtl/mem_bus_arbiter_if.sv | 64 ++++++
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles the three bus ports of mem_bus_arbiter: the instruction-fetch
//   master port (i_*), the load/store master port (d_*) and the shared
//   memory port (m_*).
//
//   Modports:
//     slave  - the arbiter's view: it accepts requests from the two core
//              masters, issues requests to memory and returns responses.
//     master - the environment's view (core ports and memory model), the
//              mirror image of slave.
//
//   Parameters: ADDR_WIDTH (address width), DATA_WIDTH (data width; the
//   write mask is DATA_WIDTH/8 bits).
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Fetch master port
    logic                    i_req_valid;
    logic                    i_req_ready;
    logic [ADDR_WIDTH-1:0]   i_req_addr;
    logic                    i_rsp_valid;
    logic [DATA_WIDTH-1:0]   i_rsp_data;

    // Load/store master port
    logic                    d_req_valid;
    logic                    d_req_ready;
    logic [ADDR_WIDTH-1:0]   d_req_addr;
    logic                    d_req_we;
    logic [DATA_WIDTH-1:0]   d_req_wdata;
    logic [DATA_WIDTH/8-1:0] d_req_wmask;
    logic                    d_rsp_valid;
    logic [DATA_WIDTH-1:0]   d_rsp_data;

    // Shared memory port
    logic                    m_req_valid;
    logic                    m_req_ready;
    logic [ADDR_WIDTH-1:0]   m_req_addr;
    logic                    m_req_we;
    logic [DATA_WIDTH-1:0]   m_req_wdata;
    logic [DATA_WIDTH/8-1:0] m_req_wmask;
    logic                    m_rsp_valid;
    logic [DATA_WIDTH-1:0]   m_rsp_data;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wmask,
        input  m_req_ready, m_rsp_valid, m_rsp_data
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wmask,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  m_req_valid, m_req_addr, m_req_we, m_req_wdata, m_req_wmask,
        output m_req_ready, m_rsp_valid, m_rsp_data
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master / single-slave memory arbiter. The instruction-fetch port and
//   the load/store port share one multi-cycle memory port. Exactly one
//   transaction is outstanding at a time; the registered response is routed
//   back to the master that issued the request.
//
//   Ports:
//     clock        - sole clock, rising edge
//     reset        - asynchronous, active-high
//     bus          - mem_bus_arbiter_if.slave (fetch, load/store, memory)
//     busy         - a transaction is in progress (state is not IDLE)
//     protocol_err - sticky; memory response seen while not waiting for one
//
//   Configuration macro ARB_ROUND_ROBIN_EN:
//     defined   - ties in IDLE go to the master that did not win the last
//                 handshake (last_grant resets to fetch, so the first tie
//                 goes to data).
//     undefined - fixed priority, load/store over fetch.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    mem_bus_arbiter_if.slave       bus,
    output logic                   busy,
    output logic                   protocol_err
);
    localparam int MASK_W = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic                  owner_q,  owner_d;   // 1 = load/store, 0 = fetch
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  we_q,     we_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [MASK_W-1:0]     wmask_q,  wmask_d;
    logic [DATA_WIDTH-1:0] rsp_q,    rsp_d;
    logic                  perr_q,   perr_d;
    logic                  gnt_d_s,  gnt_i_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic                  last_grant_q, last_grant_d;  // 1 = data won last
`endif

    // Combinational grant, only offered while idle.
    always_comb begin
        gnt_d_s = 1'b0;
        gnt_i_s = 1'b0;
        if (state_q == S_IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.d_req_valid && bus.i_req_valid) begin
                gnt_d_s = !last_grant_q;
                gnt_i_s = last_grant_q;
            end else begin
                gnt_d_s = bus.d_req_valid;
                gnt_i_s = bus.i_req_valid;
            end
`else
            gnt_d_s = bus.d_req_valid;
            gnt_i_s = bus.i_req_valid && !bus.d_req_valid;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rsp_d   = rsp_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        // Any response outside WAIT is a memory protocol violation; it is
        // otherwise ignored and does not move the FSM.
        perr_d = perr_q || (bus.m_rsp_valid && (state_q != S_WAIT));

        case (state_q)
            S_IDLE: begin
                if (gnt_d_s) begin
                    owner_d = 1'b1;
                    addr_d  = bus.d_req_addr;
                    we_d    = bus.d_req_we;
                    wdata_d = bus.d_req_wdata;
                    wmask_d = bus.d_req_wmask;
                    state_d = S_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b1;
`endif
                end else if (gnt_i_s) begin
                    // Fetches are always reads with an empty mask.
                    owner_d = 1'b0;
                    addr_d  = bus.i_req_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    state_d = S_REQ;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (bus.m_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.m_rsp_valid) begin
                    // A write acknowledge returns no data to the master.
                    rsp_d   = we_q ? '0 : bus.m_rsp_data;
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rsp_q   <= '0;
            perr_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rsp_q   <= rsp_d;
            perr_q  <= perr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.i_req_ready = gnt_i_s;
    assign bus.d_req_ready = gnt_d_s;

    assign bus.m_req_valid = (state_q == S_REQ);
    assign bus.m_req_addr  = addr_q;
    assign bus.m_req_we    = we_q;
    assign bus.m_req_wdata = wdata_q;
    assign bus.m_req_wmask = wmask_q;

    // Both masters see the single response register; only the valid
    // flags identify the owner.
    assign bus.i_rsp_valid = (state_q == S_RESP) && !owner_q;
    assign bus.d_rsp_valid = (state_q == S_RESP) &&  owner_q;
    assign bus.i_rsp_data  = rsp_q;
    assign bus.d_rsp_data  = rsp_q;

    assign busy         = (state_q != S_IDLE);
    assign protocol_err = perr_q;
endmodule
